// File: rtl/integral_image_gen_pkg.sv
// Shared types and helpers for the integral image (summed-area table) generator.
// Holds default widths, the frame FSM state type and a saturating adder used
// when IIG_SATURATE_EN is defined.
package iig_pkg;

    localparam int PIX_W_DEF     = 8;
    localparam int SUM_W_DEF     = 32;
    localparam int MAX_WIDTH_DEF = 1024;
    localparam int ADDR_W_DEF    = 17;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } fsm_t;

    // Unsigned add clamped to the all-ones value of a w-bit result (w <= 64).
    function automatic logic [63:0] sat_add(input logic [63:0] a,
                                            input logic [63:0] b,
                                            input int unsigned w);
        logic [64:0] s;
        logic [64:0] m;
        s = {1'b0, a} + {1'b0, b};
        m = (65'd1 << w) - 65'd1;
        return (s > m) ? m[63:0] : s[63:0];
    endfunction

endpackage

// File: rtl/integral_image_gen_if.sv
// Pixel-in / integral-out streaming bus of the integral image generator.
// Ports: pix_valid/pix_ready/pix_data (pixel stream), sum_valid/sum_ready/
// sum_data/sum_addr (integral stream). master = pixel source and sum sink.
interface integral_image_gen_if
    import iig_pkg::*;
#(
    parameter int PIX_W  = PIX_W_DEF,
    parameter int SUM_W  = SUM_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
);
    logic              pix_valid;
    logic              pix_ready;
    logic [PIX_W-1:0]  pix_data;
    logic              sum_valid;
    logic              sum_ready;
    logic [SUM_W-1:0]  sum_data;
    logic [ADDR_W-1:0] sum_addr;

    modport master (
        output pix_valid, pix_data, sum_ready,
        input  pix_ready, sum_valid, sum_data, sum_addr
    );

    modport slave (
        input  pix_valid, pix_data, sum_ready,
        output pix_ready, sum_valid, sum_data, sum_addr
    );
endinterface

// File: rtl/integral_image_gen_line_buffer.sv
// One-row store of integral values from the previous image row.
// Ports: clk, we/waddr/wdata (synchronous write), raddr/rdata (combinational read).
// A read and write to the same address in one cycle returns the old contents.
module iig_line_buffer #(
    parameter int DEPTH  = 1024,
    parameter int DATA_W = 32,
    parameter int AW     = 10
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);
    // Contents are never reset: row 0 masks the read, so stale data is harmless.
    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/integral_image_gen.sv
// Streaming integral image builder: raster pixels in, ii(x,y) with linear address out.
// Latency 1 cycle, 1 pixel/clk; pix_ready = !sum_valid || sum_ready, output held until taken.
// Backpressure: a stalled sum output stalls pixel input; no data is dropped.
// Ports: clk, reset (async active-low), start/img_width/img_height (frame setup),
// bus (integral_image_gen_if.slave: pixel and sum streams), busy, done, cfg_err.
// Build option: define IIG_SATURATE_EN to saturate every add instead of wrapping.
module integral_image_gen
    import iig_pkg::*;
#(
    parameter int PIX_W     = PIX_W_DEF,
    parameter int SUM_W     = SUM_W_DEF,
    parameter int MAX_WIDTH = MAX_WIDTH_DEF,
    parameter int ADDR_W    = ADDR_W_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [15:0]          img_width,
    input  logic [15:0]          img_height,
    integral_image_gen_if.slave  bus,
    output logic                 busy,
    output logic                 done,
    output logic                 cfg_err
);
    localparam int LB_AW = (MAX_WIDTH > 1) ? $clog2(MAX_WIDTH) : 1;

    localparam logic [1:0] S_IDLE  = IDLE;
    localparam logic [1:0] S_RUN   = RUN;
    localparam logic [1:0] S_FLUSH = FLUSH;

    logic [1:0]        state;
    logic [15:0]       width_r, height_r, x, y;
    logic [ADDR_W-1:0] addr_cnt, sum_addr_r;
    logic [SUM_W-1:0]  row_acc, sum_data_r;
    logic              sum_valid_r, done_r, cfg_err_r;

    logic [SUM_W-1:0]  lb_rd, row_base, row_new, above, total;
    logic              pix_ready_c, xfer, out_take, last_pix, cfg_ok;

    assign pix_ready_c = (state == S_RUN) && (!sum_valid_r || bus.sum_ready);
    assign xfer        = bus.pix_valid && pix_ready_c;
    assign out_take    = sum_valid_r && bus.sum_ready;
    assign last_pix    = (x == width_r - 16'd1) && (y == height_r - 16'd1);
    assign cfg_ok      = (img_width != 16'd0) && (int'(img_width) <= MAX_WIDTH)
                         && (img_height != 16'd0);

    // Row 0 must ignore the line buffer: it may hold a previous or aborted frame.
    always_comb begin
        row_base = (x == 16'd0) ? '0 : row_acc;
        above    = (y == 16'd0) ? '0 : lb_rd;
`ifdef IIG_SATURATE_EN
        row_new  = SUM_W'(sat_add(64'(row_base), 64'(bus.pix_data), SUM_W));
        total    = SUM_W'(sat_add(64'(row_new), 64'(above), SUM_W));
`else
        row_new  = row_base + SUM_W'(bus.pix_data);
        total    = row_new + above;
`endif
    end

    // Same address for read and write: the old ii(x,y-1) is consumed while
    // ii(x,y) replaces it for the next row.
    iig_line_buffer #(
        .DEPTH  (MAX_WIDTH),
        .DATA_W (SUM_W),
        .AW     (LB_AW)
    ) u_line_buffer (
        .clk   (clk),
        .we    (xfer),
        .waddr (x[LB_AW-1:0]),
        .wdata (total),
        .raddr (x[LB_AW-1:0]),
        .rdata (lb_rd)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= S_IDLE;
            width_r     <= '0;
            height_r    <= '0;
            x           <= '0;
            y           <= '0;
            addr_cnt    <= '0;
            sum_addr_r  <= '0;
            row_acc     <= '0;
            sum_data_r  <= '0;
            sum_valid_r <= 1'b0;
            done_r      <= 1'b0;
            cfg_err_r   <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (cfg_ok) begin
                            state     <= S_RUN;
                            width_r   <= img_width;
                            height_r  <= img_height;
                            x         <= '0;
                            y         <= '0;
                            addr_cnt  <= '0;
                            cfg_err_r <= 1'b0;
                        end else begin
                            cfg_err_r <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    if (xfer) begin
                        row_acc     <= row_new;
                        sum_data_r  <= total;
                        sum_addr_r  <= addr_cnt;
                        addr_cnt    <= addr_cnt + 1'b1;
                        sum_valid_r <= 1'b1;
                        if (x == width_r - 16'd1) begin
                            x <= '0;
                            y <= y + 16'd1;
                        end else begin
                            x <= x + 16'd1;
                        end
                        if (last_pix) begin
                            state <= S_FLUSH;
                        end
                    end else if (out_take) begin
                        sum_valid_r <= 1'b0;
                    end
                end
                S_FLUSH: begin
                    if (out_take) begin
                        sum_valid_r <= 1'b0;
                        state       <= S_IDLE;
                        done_r      <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.pix_ready = pix_ready_c;
    assign bus.sum_valid = sum_valid_r;
    assign bus.sum_data  = sum_data_r;
    assign bus.sum_addr  = sum_addr_r;
    assign busy          = (state != S_IDLE);
    assign done          = done_r;
    assign cfg_err       = cfg_err_r;
endmodule

// File: tb/tb_integral_image_gen.sv
// Bench for integral_image_gen: two instances (SUM_W 32 and 12) run in lockstep on
// the same stimulus; every accepted sum is compared with a rectangle-sum reference.
module tb_integral_image_gen;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] img_width, img_height;
    logic        pix_valid, sum_ready;
    logic [7:0]  pix_data;
    logic        busy_a, done_a, cfg_a, busy_b, done_b, cfg_b;

    int     checks = 0;
    int     errors = 0;
    longint last_a, last_b;

    always #5 clk = ~clk;

    integral_image_gen_if #(.PIX_W(8), .SUM_W(32), .ADDR_W(17)) bus_a ();
    integral_image_gen_if #(.PIX_W(8), .SUM_W(12), .ADDR_W(17)) bus_b ();

    assign bus_a.pix_valid = pix_valid;
    assign bus_a.pix_data  = pix_data;
    assign bus_a.sum_ready = sum_ready;
    assign bus_b.pix_valid = pix_valid;
    assign bus_b.pix_data  = pix_data;
    assign bus_b.sum_ready = sum_ready;

    integral_image_gen #(.PIX_W(8), .SUM_W(32), .MAX_WIDTH(16), .ADDR_W(17)) dut_a (
        .clk(clk), .reset(reset), .start(start), .img_width(img_width),
        .img_height(img_height), .bus(bus_a), .busy(busy_a), .done(done_a), .cfg_err(cfg_a)
    );

    integral_image_gen #(.PIX_W(8), .SUM_W(12), .MAX_WIDTH(16), .ADDR_W(17)) dut_b (
        .clk(clk), .reset(reset), .start(start), .img_width(img_width),
        .img_height(img_height), .bus(bus_b), .busy(busy_b), .done(done_b), .cfg_err(cfg_b)
    );

    // Reduce a true (unbounded) sum to a w-bit result.
    function automatic longint fit(input longint s, input int w);
        longint m;
        m = (longint'(1) << w) - 1;
`ifdef IIG_SATURATE_EN
        return (s > m) ? m : s;
`else
        return s & m;
`endif
    endfunction

    // mode: 0 ones, 1 counting from 1, 2 all 255, 3 random, 4 counting from 5
    task automatic run_frame(input int w, input int h, input int mode, input bit gaps,
                             input int stall_addr, input bit poke);
        int     n, in_idx, out_idx, cyc, tail, stall_left, dn_a, dn_b;
        bit     stalled;
        longint img[];
        longint ex[];
        n = w * h;
        img = new[n];
        ex  = new[n];
        for (int i = 0; i < n; i++) begin
            case (mode)
                0:       img[i] = 1;
                1:       img[i] = i + 1;
                2:       img[i] = 255;
                4:       img[i] = i + 5;
                default: img[i] = longint'($urandom_range(0, 255));
            endcase
        end
        // ii(x,y) straight from its definition: sum of the rectangle [0..x]x[0..y].
        for (int i = 0; i < n; i++) begin
            longint s;
            s = 0;
            for (int r = 0; r <= i / w; r++)
                for (int c = 0; c <= i % w; c++)
                    s += img[r * w + c];
            ex[i] = s;
        end

        img_width  = 16'(w);
        img_height = 16'(h);
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (busy_a !== 1'b1 || cfg_a !== 1'b0)
            $display("FAIL start_%0dx%0d busy=%b cfg_err=%b required busy=1 cfg_err=0", w, h, busy_a, cfg_a);
        else if (0) ;
        if (busy_a !== 1'b1 || cfg_a !== 1'b0) errors++;

        in_idx = 0; out_idx = 0; cyc = 0; tail = 0; stall_left = 3; dn_a = 0; dn_b = 0;
        while (tail < 4 && cyc < 4000) begin
            cyc++;
            if (in_idx < n) begin
                pix_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
                pix_data  = 8'(img[in_idx]);
            end else begin
                pix_valid = 1'b0;
                pix_data  = 8'd0;
            end
            stalled = 1'b0;
            if (stall_addr >= 0 && bus_a.sum_valid && int'(bus_a.sum_addr) == stall_addr
                && stall_left > 0) begin
                sum_ready = 1'b0;
                stall_left--;
                stalled = 1'b1;
            end else begin
                sum_ready = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            end
            // A start while a frame is running must be ignored.
            if (poke && in_idx < n && $urandom_range(0, 7) == 0) begin
                start      = 1'b1;
                img_width  = 16'($urandom_range(0, 20));
                img_height = 16'($urandom_range(0, 3));
            end
            #1;
            if (stalled) begin
                checks++;
                if (bus_a.pix_ready !== 1'b0 || longint'(bus_a.sum_data) !== fit(ex[stall_addr], 32)) begin
                    errors++;
                    $display("FAIL stall_hold pix_ready=%b sum=%0d required pix_ready=0 sum=%0d",
                             bus_a.pix_ready, bus_a.sum_data, fit(ex[stall_addr], 32));
                end
            end
            if (in_idx == n) begin
                checks++;
                if (bus_a.pix_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL flush_pix_ready got=%b required=0", bus_a.pix_ready);
                end
            end
            if (pix_valid && bus_a.pix_ready) in_idx++;
            if (bus_a.sum_valid === 1'b1 && sum_ready) begin
                checks++;
                if (out_idx >= n) begin
                    errors++;
                    $display("FAIL extra_output addr=%0d required no output", bus_a.sum_addr);
                end else if (longint'(bus_a.sum_data) !== fit(ex[out_idx], 32)
                             || int'(bus_a.sum_addr) !== out_idx
                             || bus_b.sum_valid !== 1'b1
                             || longint'(bus_b.sum_data) !== fit(ex[out_idx], 12)) begin
                    errors++;
                    $display("FAIL sum_%0d got a=%0d@%0d b=%0d required a=%0d@%0d b=%0d", out_idx,
                             bus_a.sum_data, bus_a.sum_addr, bus_b.sum_data,
                             fit(ex[out_idx], 32), out_idx, fit(ex[out_idx], 12));
                end
                if (out_idx < n) begin
                    last_a = longint'(bus_a.sum_data);
                    last_b = longint'(bus_b.sum_data);
                end
                out_idx++;
            end
            @(negedge clk);
            start = 1'b0;
            if (done_a === 1'b1) dn_a++;
            if (done_b === 1'b1) dn_b++;
            if (out_idx >= n) tail++;
        end
        pix_valid = 1'b0;
        sum_ready = 1'b0;
        checks++;
        if (out_idx != n || dn_a != 1 || dn_b != 1 || busy_a !== 1'b0) begin
            errors++;
            $display("FAIL frame_end_%0dx%0d outputs=%0d done=%0d/%0d busy=%b required outputs=%0d done=1/1 busy=0",
                     w, h, out_idx, dn_a, dn_b, busy_a, n);
        end
    endtask

    task automatic test_reset;
        checks++;
        if (busy_a !== 1'b0 || done_a !== 1'b0 || cfg_a !== 1'b0 || bus_a.sum_valid !== 1'b0
            || bus_a.pix_ready !== 1'b0 || bus_a.sum_data !== 32'd0 || bus_a.sum_addr !== 17'd0
            || busy_b !== 1'b0 || bus_b.sum_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_state busy=%b done=%b cfg=%b sv=%b pr=%b sd=%0d sa=%0d required all 0",
                     busy_a, done_a, cfg_a, bus_a.sum_valid, bus_a.pix_ready, bus_a.sum_data, bus_a.sum_addr);
        end
    endtask

    task automatic test_basic_2x2;
        run_frame(2, 2, 0, 1'b0, -1, 1'b0);
        checks++;
        if (last_a !== 64'd4) begin
            errors++;
            $display("FAIL basic_2x2_last got=%0d required=4", last_a);
        end
    endtask

    task automatic test_3x3;
        run_frame(3, 3, 1, 1'b0, -1, 1'b0);
        checks++;
        if (last_a !== 64'd45) begin
            errors++;
            $display("FAIL count_3x3_last got=%0d required=45", last_a);
        end
    endtask

    task automatic test_backpressure;
        run_frame(3, 3, 1, 1'b0, 4, 1'b0);
    endtask

    task automatic test_wrap;
        run_frame(4, 4, 2, 1'b0, -1, 1'b0);
        checks++;
        if (last_b !== 64'd4080) begin
            errors++;
            $display("FAIL w12_4x4_last got=%0d required=4080", last_b);
        end
        run_frame(8, 8, 2, 1'b1, -1, 1'b0);
        checks++;
`ifdef IIG_SATURATE_EN
        if (last_b !== 64'd4095 || last_a !== 64'd16320) begin
            errors++;
            $display("FAIL w12_8x8_last got=%0d/%0d required=4095/16320", last_b, last_a);
        end
`else
        if (last_b !== 64'd4032 || last_a !== 64'd16320) begin
            errors++;
            $display("FAIL w12_8x8_last got=%0d/%0d required=4032/16320", last_b, last_a);
        end
`endif
    endtask

    task automatic test_reset_mid;
        int cnt, cyc, dn;
        img_width  = 16'd3;
        img_height = 16'd2;
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cnt = 0; cyc = 0; dn = 0;
        pix_valid = 1'b1;
        sum_ready = 1'b1;
        while (cnt < 4 && cyc < 50) begin
            cyc++;
            pix_data = 8'(cnt + 7);
            #1;
            if (bus_a.pix_ready) cnt++;
            @(negedge clk);
            if (done_a === 1'b1) dn++;
        end
        reset = 1'b0;
        pix_valid = 1'b0;
        #1;
        checks++;
        if (cnt != 4 || dn != 0 || busy_a !== 1'b0 || bus_a.sum_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_abort xfers=%0d done=%0d busy=%b sv=%b required 4 0 0 0",
                     cnt, dn, busy_a, bus_a.sum_valid);
        end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (done_a !== 1'b0 || busy_a !== 1'b0) begin
            errors++;
            $display("FAIL reset_release done=%b busy=%b required 0 0", done_a, busy_a);
        end
        run_frame(2, 1, 4, 1'b0, -1, 1'b0);
        checks++;
        if (last_a !== 64'd11) begin
            errors++;
            $display("FAIL restart_last got=%0d required=11", last_a);
        end
    endtask

    task automatic test_cfg_err;
        int bad_w[3] = '{0, 17, 5};
        int bad_h[3] = '{3, 2, 0};
        for (int i = 0; i < 3; i++) begin
            img_width  = 16'(bad_w[i]);
            img_height = 16'(bad_h[i]);
            start      = 1'b1;
            @(negedge clk);
            start = 1'b0;
            checks++;
            if (cfg_a !== 1'b1 || busy_a !== 1'b0 || cfg_b !== 1'b1) begin
                errors++;
                $display("FAIL cfg_reject_%0dx%0d cfg_err=%b busy=%b required cfg_err=1 busy=0",
                         bad_w[i], bad_h[i], cfg_a, busy_a);
            end
        end
        // Widest legal row: accepted, and clears the sticky error.
        run_frame(16, 2, 3, 1'b1, -1, 1'b0);
    endtask

    task automatic test_random;
        for (int k = 0; k < 6; k++)
            run_frame($urandom_range(1, 16), $urandom_range(1, 4), 3, 1'b1, -1, 1'b1);
        run_frame(1, 5, 3, 1'b1, -1, 1'b0);
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; pix_valid = 1'b0; pix_data = 8'd0; sum_ready = 1'b0;
        img_width = 16'd0; img_height = 16'd0; last_a = 0; last_b = 0;
        repeat (3) @(negedge clk);
        test_reset();
        reset = 1'b1;
        @(negedge clk);
        test_basic_2x2();
        test_3x3();
        test_backpressure();
        test_wrap();
        test_reset_mid();
        test_cfg_err();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
